bcsa_pipe: RTL

//  Parametrised, pipelined block carry-speculative adder; next generation of the 16-bit/8-bit BCSA.

---
 rtl/bcsa_pipe_if.sv | 25 ++
 rtl/bcsa_pipe.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bcsa_pipe_if.sv
// Valid/ready operand and result stream of the bcsa_pipe adder.
// The master side drives operands and out_ready; the slave side is the adder.
interface bcsa_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_exact;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_exact, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_exact, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/bcsa_pipe.sv
// Two-stage pipelined block carry-speculative adder with a saturating error counter.
// Each block's carry-in is speculated from the previous block alone, or fully propagated.
module bcsa_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bcsa_pipe_if.slave       strm,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int unsigned NBLK = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || BLOCK < 2) begin : g_bad_param
        $error("bcsa_pipe: WIDTH must be a multiple of BLOCK and BLOCK must be >= 2");
    end

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_exact;
    logic [NBLK-1:0]  s1_cadd;
    logic [NBLK-1:0]  s1_sel;
    logic             s2_valid;
    logic [WIDTH:0]   s2_sum;
    logic             s2_err;
    logic [CNT_W-1:0] cnt;

    logic             s1_adv;
    logic             s2_adv;
    logic [NBLK-1:0]  cadd_d;
    logic [NBLK-1:0]  sel_d;
    logic [BLOCK:0]   lo_sum;
    logic [WIDTH:0]   true_sum;
    logic [WIDTH:0]   sum_d;
    logic [NBLK-1:0]  cin_used;
    logic [BLOCK:0]   blk_sum;
    logic             err_d;

    assign s2_adv        = ~s2_valid | strm.out_ready;
    assign s1_adv        = ~s1_valid | s2_adv;
    assign strm.in_ready = s1_adv;

    // Stage 1 speculation terms; block 0 is pinned to sel=1, cadd=0 so its carry-in is 0.
    always_comb begin
        cadd_d    = '0;
        sel_d     = '0;
        sel_d[0]  = 1'b1;
        lo_sum    = '0;
        for (int k = 1; k < NBLK; k++) begin
            lo_sum    = {1'b0, strm.in_a[(k-1)*BLOCK +: BLOCK]}
                      + {1'b0, strm.in_b[(k-1)*BLOCK +: BLOCK]};
            cadd_d[k] = lo_sum[BLOCK];
            sel_d[k]  = (strm.in_a[k*BLOCK-1] & strm.in_b[k*BLOCK-1])
                      | (~strm.in_a[k*BLOCK] & ~strm.in_b[k*BLOCK]);
        end
    end

    // Stage 2: pick each block's carry-in, sum the blocks, compare against the exact sum.
    always_comb begin
        true_sum    = {1'b0, s1_a} + {1'b0, s1_b};
        cin_used    = '0;
        cin_used[0] = s1_sel[0] ? 1'b0 : s1_cadd[0];
        for (int k = 1; k < NBLK; k++) begin
            if (s1_exact) begin
                cin_used[k] = true_sum[k*BLOCK] ^ s1_a[k*BLOCK] ^ s1_b[k*BLOCK];
            end else begin
                cin_used[k] = s1_sel[k] ? (s1_a[k*BLOCK-1] & s1_b[k*BLOCK-1]) : s1_cadd[k];
            end
        end
        sum_d   = '0;
        blk_sum = '0;
        for (int k = 0; k < NBLK; k++) begin
            blk_sum = {1'b0, s1_a[k*BLOCK +: BLOCK]} + {1'b0, s1_b[k*BLOCK +: BLOCK]}
                    + {{BLOCK{1'b0}}, cin_used[k]};
            sum_d[k*BLOCK +: BLOCK] = blk_sum[BLOCK-1:0];
        end
        sum_d[WIDTH] = blk_sum[BLOCK];
        err_d        = (sum_d != true_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_exact <= 1'b0;
            s1_cadd  <= '0;
            s1_sel   <= '0;
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_err   <= 1'b0;
            cnt      <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= strm.in_valid;
                if (strm.in_valid) begin
                    s1_a     <= strm.in_a;
                    s1_b     <= strm.in_b;
                    s1_exact <= strm.in_exact;
                    s1_cadd  <= cadd_d;
                    s1_sel   <= sel_d;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sum <= sum_d;
                    s2_err <= err_d;
                end
            end
            if (err_clr) begin
                cnt <= '0;
            end else if (s2_valid && strm.out_ready && s2_err && !(&cnt)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign strm.out_valid = s2_valid;
    assign strm.out_sum   = s2_sum;
    assign strm.out_err   = s2_err;
    assign err_cnt        = cnt;
endmodule
